// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the LEGv8 immediate generator.
// Opcodes are matched on instr[31:21]; each class uses a care mask that
// blanks the low opcode bits which belong to the immediate or to hw.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_ALU  = 3'd1,
    IMM_MEM  = 3'd2,
    IMM_CB   = 3'd3,
    IMM_B    = 3'd4,
    IMM_MOV  = 3'd5
  } imm_kind_t;

  localparam int OP_W = 11;

  // I-format: 10-bit opcode in [31:22], bit 21 is the imm12 MSB.
  localparam logic [OP_W-1:0] OPM_I     = 11'b11111111110;
  localparam logic [OP_W-1:0] OP_ADDI   = 11'b10010001000;
  localparam logic [OP_W-1:0] OP_ADDIS  = 11'b10110001000;
  localparam logic [OP_W-1:0] OP_ANDI   = 11'b10010010000;
  localparam logic [OP_W-1:0] OP_ANDIS  = 11'b11110010000;
  localparam logic [OP_W-1:0] OP_EORI   = 11'b11010010000;
  localparam logic [OP_W-1:0] OP_ORRI   = 11'b10110010000;
  localparam logic [OP_W-1:0] OP_SUBI   = 11'b11010001000;
  localparam logic [OP_W-1:0] OP_SUBIS  = 11'b11110001000; // also CMPI

  // D-format: full 11-bit opcode.
  localparam logic [OP_W-1:0] OPM_D     = 11'b11111111111;
  localparam logic [OP_W-1:0] OP_LDUR   = 11'b11111000010;
  localparam logic [OP_W-1:0] OP_STUR   = 11'b11111000000;

  // CB-format: 8-bit opcode in [31:24].
  localparam logic [OP_W-1:0] OPM_CB    = 11'b11111111000;
  localparam logic [OP_W-1:0] OP_CBZ    = 11'b10110100000;
  localparam logic [OP_W-1:0] OP_CBNZ   = 11'b10110101000;
  localparam logic [OP_W-1:0] OP_BCOND  = 11'b01010100000;

  // B-format: 6-bit opcode in [31:26].
  localparam logic [OP_W-1:0] OPM_B     = 11'b11111100000;
  localparam logic [OP_W-1:0] OP_B      = 11'b00010100000;
  localparam logic [OP_W-1:0] OP_BL     = 11'b10010100000;

  // IW-format: 9-bit opcode in [31:23], hw in [22:21].
  localparam logic [OP_W-1:0] OPM_MOV   = 11'b11111111100;
  localparam logic [OP_W-1:0] OP_MOVZ   = 11'b11010010100;
  localparam logic [OP_W-1:0] OP_MOVK   = 11'b11110010100;

  function automatic logic op_is(input logic [OP_W-1:0] op,
                                 input logic [OP_W-1:0] val,
                                 input logic [OP_W-1:0] mask);
    return (op & mask) == val;
  endfunction

  function automatic logic is_alu_op(input logic [OP_W-1:0] op);
    return op_is(op, OP_ADDI,  OPM_I) | op_is(op, OP_ADDIS, OPM_I) |
           op_is(op, OP_ANDI,  OPM_I) | op_is(op, OP_ANDIS, OPM_I) |
           op_is(op, OP_EORI,  OPM_I) | op_is(op, OP_ORRI,  OPM_I) |
           op_is(op, OP_SUBI,  OPM_I) | op_is(op, OP_SUBIS, OPM_I);
  endfunction

  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return op_is(op, OP_LDUR, OPM_D) | op_is(op, OP_STUR, OPM_D);
  endfunction

  function automatic logic is_cb_op(input logic [OP_W-1:0] op);
    return op_is(op, OP_CBZ, OPM_CB) | op_is(op, OP_CBNZ, OPM_CB) |
           op_is(op, OP_BCOND, OPM_CB);
  endfunction

  function automatic logic is_b_op(input logic [OP_W-1:0] op);
    return op_is(op, OP_B, OPM_B) | op_is(op, OP_BL, OPM_B);
  endfunction

  function automatic logic is_mov_op(input logic [OP_W-1:0] op);
    return op_is(op, OP_MOVZ, OPM_MOV) | op_is(op, OP_MOVK, OPM_MOV);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: classifies the instruction and builds
// the WORD-wide extended immediate. Everything is formed at 64 bits and
// truncated at the end, so shifted-out bits above WORD-1 simply vanish.
module imm_decode
  import imm_pkg::*;
#(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int BR_SHIFT  = 1
) (
  input  logic [INSTR_LEN-1:0] instr,
  output logic [WORD-1:0]      imm,
  output imm_kind_t            kind,
  output logic                 illegal
);

  // Branch offsets are either word counts or byte offsets (x4).
  localparam int BR_SH = (BR_SHIFT != 0) ? 2 : 0;

  logic [OP_W-1:0] op;
  logic [1:0]      hw;
  logic [5:0]      mov_sh;
  logic [63:0]     alu_sext;
  logic [63:0]     mem_sext;
  logic [63:0]     cb_sext;
  logic [63:0]     b_sext;
  logic [63:0]     mov_zext;
  logic [63:0]     wide;

  assign op       = instr[31:21];
  assign hw       = instr[22:21];
  assign mov_sh   = {hw, 4'b0000};
  assign alu_sext = {{52{instr[21]}}, instr[21:10]};
  assign mem_sext = {{55{instr[20]}}, instr[20:12]};
  assign cb_sext  = {{45{instr[23]}}, instr[23:5]};
  assign b_sext   = {{38{instr[25]}}, instr[25:0]};
  assign mov_zext = {48'd0, instr[20:5]};

  // Class select; unknown opcodes pass the raw instruction through.
  always_comb begin
    wide                   = '0;
    wide[INSTR_LEN-1:0]    = instr;
    kind                   = IMM_NONE;
    illegal                = 1'b0;
    if (is_alu_op(op)) begin
      wide = alu_sext;
      kind = IMM_ALU;
    end else if (is_mem_op(op)) begin
      wide = mem_sext;
      kind = IMM_MEM;
    end else if (is_cb_op(op)) begin
      wide = cb_sext << BR_SH;
      kind = IMM_CB;
    end else if (is_b_op(op)) begin
      wide = b_sext << BR_SH;
      kind = IMM_B;
    end else if (is_mov_op(op)) begin
      kind = IMM_MOV;
      // A halfword slot at or beyond WORD cannot hold the value.
      if ((int'(hw) * 16) >= WORD) begin
        wide    = '0;
        illegal = 1'b1;
      end else begin
        wide = mov_zext << mov_sh;
      end
    end
  end

  assign imm = wide[WORD-1:0];

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate-generator stage between IF/ID and ID/EX.
// Handshake: a transfer happens at a rising edge where valid & ready are
// both high; out_valid and out_* stay put until out_ready; in_ready is a
// flop that only reflects skid occupancy (low exactly when the skid entry
// is full), so it never depends combinationally on out_ready.
// Storage is an output register plus one skid entry, giving a 2-deep FIFO
// that keeps full throughput while out_ready is high.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int TAG_W     = 64,
  parameter int BR_SHIFT  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_imm,
  output logic [2:0]           out_kind,
  output logic                 out_illegal,
  output logic [TAG_W-1:0]     out_tag
);

  logic [WORD-1:0] dec_imm;
  imm_kind_t       dec_kind;
  logic            dec_illegal;

  imm_decode #(
    .WORD      (WORD),
    .INSTR_LEN (INSTR_LEN),
    .BR_SHIFT  (BR_SHIFT)
  ) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .kind    (dec_kind),
    .illegal (dec_illegal)
  );

  logic            out_valid_q, out_valid_d;
  logic [WORD-1:0] out_imm_q,   out_imm_d;
  imm_kind_t       out_kind_q,  out_kind_d;
  logic            out_ill_q,   out_ill_d;
  logic [TAG_W-1:0] out_tag_q,  out_tag_d;

  logic            skid_valid_q, skid_valid_d;
  logic [WORD-1:0] skid_imm_q,   skid_imm_d;
  imm_kind_t       skid_kind_q,  skid_kind_d;
  logic            skid_ill_q,   skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;

  logic            in_ready_q, in_ready_d;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  // Next-state for output register, skid entry and in_ready.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_kind_d   = out_kind_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_kind_d  = skid_kind_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;

    if (flush) begin
      // Flush wins over drain and accept; any input this cycle is dropped.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-output move can happen.
      if (drain) begin
        out_imm_d    = skid_imm_q;
        out_kind_d   = skid_kind_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (!out_valid_q || drain) begin
      // Output register is free (or freeing): new result goes straight in.
      out_valid_d = accept;
      if (accept) begin
        out_imm_d  = dec_imm;
        out_kind_d = dec_kind;
        out_ill_d  = dec_illegal;
        out_tag_d  = in_tag;
      end
    end else if (accept) begin
      // Output stalled: park the result in the skid entry.
      skid_valid_d = 1'b1;
      skid_imm_d   = dec_imm;
      skid_kind_d  = dec_kind;
      skid_ill_d   = dec_illegal;
      skid_tag_d   = in_tag;
    end

    in_ready_d = ~skid_valid_d;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_kind_q   <= IMM_NONE;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_kind_q  <= IMM_NONE;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_kind_q   <= out_kind_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_kind_q  <= skid_kind_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_kind    = out_kind_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two instances (WORD=64/BR_SHIFT=1 and
// WORD=32/BR_SHIFT=0) share one input stream. A queue model predicts the
// contents and handshake of each; directed vectors pin literal values.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  localparam int EW = 132; // {tag[63:0], illegal, kind[2:0], imm[63:0]}

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_tag;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [63:0] a_out_imm, a_out_tag;
  logic [2:0]  a_out_kind;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [31:0] b_out_imm;
  logic [63:0] b_out_tag;
  logic [2:0]  b_out_kind;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit accepted = 1'b0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_b_q[$];
  logic [63:0]   got_q[$];
  int            got_cyc[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  imm_gen_pipe #(.WORD(64), .INSTR_LEN(32), .TAG_W(64), .BR_SHIFT(1)) u_dut_a (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_kind(a_out_kind),
    .out_illegal(a_out_illegal), .out_tag(a_out_tag)
  );

  imm_gen_pipe #(.WORD(32), .INSTR_LEN(32), .TAG_W(64), .BR_SHIFT(0)) u_dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_kind(b_out_kind),
    .out_illegal(b_out_illegal), .out_tag(b_out_tag)
  );

  // ---------------- model ----------------
  function automatic logic [EW-1:0] model(input logic [31:0] ins,
                                          input logic [63:0] tag,
                                          input int word, input int brs);
    logic [10:0] op;
    longint      v;
    int          k;
    bit          ill;
    int          hw;
    logic [63:0] res;
    op  = ins[31:21];
    v   = longint'({32'd0, ins});
    k   = 0;
    ill = 1'b0;
    if (op inside {11'b1001000100?, 11'b1011000100?, 11'b1001001000?,
                   11'b1111001000?, 11'b1101001000?, 11'b1011001000?,
                   11'b1101000100?, 11'b1111000100?}) begin
      v = $signed(ins[21:10]);
      k = 1;
    end else if (op inside {11'b11111000010, 11'b11111000000}) begin
      v = $signed(ins[20:12]);
      k = 2;
    end else if (op inside {11'b10110100???, 11'b10110101???, 11'b01010100???}) begin
      v = $signed(ins[23:5]);
      v = v * ((brs != 0) ? 4 : 1);
      k = 3;
    end else if (op inside {11'b000101?????, 11'b100101?????}) begin
      v = $signed(ins[25:0]);
      v = v * ((brs != 0) ? 4 : 1);
      k = 4;
    end else if (op inside {11'b110100101??, 11'b111100101??}) begin
      k  = 5;
      hw = int'(ins[22:21]);
      if (16 * hw >= word) begin
        v   = 0;
        ill = 1'b1;
      end else begin
        v = longint'(ins[20:5]) << (16 * hw);
      end
    end
    res = 64'(v);
    if (word == 32) res = res & 64'h0000_0000_FFFF_FFFF;
    return {tag, ill, 3'(k), res};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update at each edge: flush clears, drain pops, accept pushes.
  always @(posedge clk or posedge reset) begin
    int sz;
    if (reset) begin
      exp_q.delete();
      exp_b_q.delete();
      accepted = 1'b0;
    end else begin
      cyc++;
      accepted = 1'b0;
      if (flush) begin
        exp_q.delete();
        exp_b_q.delete();
      end else begin
        sz = exp_q.size();
        if (sz > 0 && out_ready) begin
          void'(exp_q.pop_front());
          void'(exp_b_q.pop_front());
          got_q.push_back(a_out_imm);
          got_cyc.push_back(cyc);
        end
        if (in_valid && sz < 2) begin
          exp_q.push_back(model(in_instr, in_tag, 64, 1));
          exp_b_q.push_back(model(in_instr, in_tag, 32, 0));
          accepted = 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (reset) begin
      chk("rst_a_valid", 64'(a_out_valid), 64'd0);
      chk("rst_a_ready", 64'(a_in_ready), 64'd1);
      chk("rst_a_imm", a_out_imm, 64'd0);
      chk("rst_a_kind", 64'(a_out_kind), 64'(IMM_NONE));
      chk("rst_a_ill", 64'(a_out_illegal), 64'd0);
      chk("rst_a_tag", a_out_tag, 64'd0);
      chk("rst_b_valid", 64'(b_out_valid), 64'd0);
      chk("rst_b_ready", 64'(b_in_ready), 64'd1);
    end else begin
      chk("a_valid", 64'(a_out_valid), 64'(exp_q.size() != 0));
      chk("a_ready", 64'(a_in_ready), 64'(exp_q.size() < 2));
      chk("b_valid", 64'(b_out_valid), 64'(exp_b_q.size() != 0));
      chk("b_ready", 64'(b_in_ready), 64'(exp_b_q.size() < 2));
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("a_imm", a_out_imm, e[63:0]);
        chk("a_kind", 64'(a_out_kind), 64'(e[66:64]));
        chk("a_ill", 64'(a_out_illegal), 64'(e[67]));
        chk("a_tag", a_out_tag, e[131:68]);
      end
      if (exp_b_q.size() != 0) begin
        e = exp_b_q[0];
        chk("b_imm", 64'(b_out_imm), e[63:0]);
        chk("b_kind", 64'(b_out_kind), 64'(e[66:64]));
        chk("b_ill", 64'(b_out_illegal), 64'(e[67]));
        chk("b_tag", b_out_tag, e[131:68]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction and hold it until the model sees it accepted.
  task automatic send(input logic [31:0] ins, input logic [63:0] tag);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_instr = ins;
    in_tag   = tag;
    do begin
      tick();
      guard++;
    end while (!accepted && guard < 50);
    if (!accepted) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: instr %h not accepted within %0d cycles", ins, guard);
    end
    in_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  logic [31:0] v_ins   [7];
  logic [63:0] v_aimm  [7];
  logic [2:0]  v_kind  [7];
  logic [31:0] v_bimm  [7];
  logic        v_bill  [7];

  initial begin
    v_ins  = '{32'h913FFC41, 32'h17FFFFFF, 32'hD2F579A0, 32'hF85F8041,
               32'hB4000083, 32'h8B020020, 32'hF2A24680};
    v_aimm = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFC,
               64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF8,
               64'h0000_0000_0000_0010, 64'h0000_0000_8B02_0020,
               64'h0000_0000_1234_0000};
    v_kind = '{IMM_ALU, IMM_B, IMM_MOV, IMM_MEM, IMM_CB, IMM_NONE, IMM_MOV};
    v_bimm = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFF8,
               32'h0000_0004, 32'h8B02_0020, 32'h1234_0000};
    v_bill = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // Single vectors, one cycle latency, literal expectations.
    for (int i = 0; i < 7; i++) begin
      send(v_ins[i], 64'h1000 + 64'(i) * 4);
      @(negedge clk);
      chk("lit_a_valid", 64'(a_out_valid), 64'd1);
      chk("lit_a_imm", a_out_imm, v_aimm[i]);
      chk("lit_a_kind", 64'(a_out_kind), 64'(v_kind[i]));
      chk("lit_a_ill", 64'(a_out_illegal), 64'd0);
      chk("lit_a_tag", a_out_tag, 64'h1000 + 64'(i) * 4);
      chk("lit_b_imm", 64'(b_out_imm), 64'(v_bimm[i]));
      chk("lit_b_kind", 64'(b_out_kind), 64'(v_kind[i]));
      chk("lit_b_ill", 64'(b_out_illegal), 64'(v_bill[i]));
    end
    tick();

    // Back-to-back stream at full throughput.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 7; i++)
        send(v_ins[i], 64'h2000 + 64'(r * 7 + i));
    repeat (2) tick();

    // Backpressure: three ADDIs (imm 1,2,3) against a stalled consumer.
    out_ready = 1'b0;
    got_q.delete();
    got_cyc.delete();
    send(32'h91000401, 64'h3001);
    send(32'h91000801, 64'h3002);
    in_valid = 1'b1;
    in_instr = 32'h91000C01;
    in_tag   = 64'h3003;
    tick();
    chk("bp_in_ready_low", 64'(a_in_ready), 64'd0);
    chk("bp_hold_imm", a_out_imm, 64'd1);
    tick();
    chk("bp_hold_imm2", a_out_imm, 64'd1);
    chk("bp_hold_valid", 64'(a_out_valid), 64'd1);
    out_ready = 1'b1;
    begin
      int guard;
      guard = 0;
      do begin
        tick();
        guard++;
      end while (!accepted && guard < 20);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("bp_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("bp_order0", got_q[0], 64'd1);
      chk("bp_order1", got_q[1], 64'd2);
      chk("bp_order2", got_q[2], 64'd3);
      chk("bp_consec1", 64'(got_cyc[1] - got_cyc[0]), 64'd1);
      chk("bp_consec2", 64'(got_cyc[2] - got_cyc[1]), 64'd1);
    end

    // Flush with output and skid full, plus an input in the flush cycle.
    out_ready = 1'b0;
    send(32'h91001001, 64'h4001);
    send(32'h91001401, 64'h4002);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h91009C01;
    in_tag   = 64'hDEAD;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_ready", 64'(a_in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (2) tick();

    // Flush with only the output full: in_ready is high but input is dropped.
    out_ready = 1'b0;
    send(32'h91001801, 64'h4003);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h9100A001;
    in_tag   = 64'hBEEF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_valid", 64'(a_out_valid), 64'd0);
    chk("fl2_b_valid", 64'(b_out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (2) tick();

    // Asynchronous reset mid-stream, between clock edges.
    out_ready = 1'b0;
    send(32'h91001C01, 64'h5001);
    send(32'h91002001, 64'h5002);
    #2 reset = 1'b1;
    #1;
    chk("ar_a_valid", 64'(a_out_valid), 64'd0);
    chk("ar_a_ready", 64'(a_in_ready), 64'd1);
    chk("ar_a_imm", a_out_imm, 64'd0);
    chk("ar_b_valid", 64'(b_out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    send(32'h913FFC41, 64'h6000);
    @(negedge clk);
    chk("ar_post_imm", a_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ar_post_kind", 64'(a_out_kind), 64'(IMM_ALU));
    chk("ar_post_b_imm", 64'(b_out_imm), 64'hFFFF_FFFF);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
